cpu_bus_sync: RTL

Front-end stage between the 6502 bus pins and the CPU-facing register logic. It samples the asynchronous 1 MHz bus (phi2, addr, data, rw, ce0, ce1b) in the clk_25mhz domain. It detects completed bus cycles on the falling edge of phi2, queues writes in a small FIFO, and emits a one-cycle read-completion pulse. Downstream register/instruction logic therefore runs entirely on clk_25mhz.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/bus_write_fifo.sv | 58 +++++
 rtl/cpu_bus_sync.sv | 108 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared bus-interface types and constants for the CPU-side logic.
// Holds the write-queue entry width, bus-cycle decode and register map.
package vga_pkg;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int WR_ENTRY_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'b00,
    BUS_WRITE = 2'b01,
    BUS_READ  = 2'b10
  } bus_cyc_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
    logic              sel;
  } bus_cap_t;

  localparam logic [ADDR_W-1:0] REG_CTRL    = 4'h0;
  localparam logic [ADDR_W-1:0] REG_STATUS  = 4'h1;
  localparam logic [ADDR_W-1:0] REG_ADDR_LO = 4'h2;
  localparam logic [ADDR_W-1:0] REG_ADDR_HI = 4'h3;
  localparam logic [ADDR_W-1:0] REG_DATA    = 4'h4;

  function automatic bus_cyc_e bus_decode(input logic sel, input logic rw);
    if (!sel) return BUS_IDLE;
    return rw ? BUS_READ : BUS_WRITE;
  endfunction

endpackage

// File: rtl/bus_write_fifo.sv
// Synchronous FIFO, power-of-two depth; push while full succeeds only with a pop.
// Head data and level come straight from registers; no same-cycle bypass.
module bus_write_fifo #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the same cycle, so a full FIFO can still take a push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/cpu_bus_sync.sv
// Brings the asynchronous 6502 bus into clk_25mhz: synchronise, capture while phi2 high,
// act on phi2 fall (queue writes, pulse rd_done for reads), sticky overflow on dropped writes.
module cpu_bus_sync
  import vga_pkg::*;
#(
  parameter  int SYNC_STAGES = 2,
  parameter  int FIFO_DEPTH  = 4,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_25mhz,
  input  logic              reset_n,
  input  logic              phi2,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rw,
  input  logic              ce0,
  input  logic              ce1b,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              rd_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int SYNC_W = 1 + ADDR_W + DATA_W + 3;

  logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
  logic              phi2_s, rw_s, ce0_s, ce1b_s, sel_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] data_s;

  bus_cap_t          cap_q, cap_d;
  logic              phi2_d_q;
  logic              rd_done_q, rd_done_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              overflow_q, overflow_d;

  logic              fall, push, pop, drop, fifo_full, fifo_empty;
  bus_cyc_e          cyc;

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {phi2, addr, data_in, rw, ce0, ce1b};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {phi2_s, addr_s, data_s, rw_s, ce0_s, ce1b_s} = sync_q[SYNC_STAGES-1];
  assign sel_s = ce0_s & ~ce1b_s;

  // Flops reset low, so phi2 already high at release cannot look like a fall.
  assign fall = phi2_d_q & ~phi2_s;
  assign cyc  = bus_decode(cap_q.sel, cap_q.rw);
  assign push = fall && (cyc == BUS_WRITE);
  assign pop  = wr_valid & wr_ready;
  assign drop = push & fifo_full & ~pop;

  always_comb begin
    cap_d = cap_q;
    if (phi2_s) cap_d = '{addr: addr_s, data: data_s, rw: rw_s, sel: sel_s};
    rd_done_d  = fall && (cyc == BUS_READ);
    rd_addr_d  = rd_done_d ? cap_q.addr : rd_addr_q;
    overflow_d = drop | (overflow_q & ~overflow_clr);
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      cap_q      <= '0;
      phi2_d_q   <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_addr_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      phi2_d_q   <= phi2_s;
      rd_done_q  <= rd_done_d;
      rd_addr_q  <= rd_addr_d;
      overflow_q <= overflow_d;
    end
  end

  bus_write_fifo #(
    .WIDTH(WR_ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk_25mhz),
    .rst_n  (reset_n),
    .push_i (push),
    .din_i  ({cap_q.addr, cap_q.data}),
    .pop_i  (pop),
    .dout_o ({wr_addr, wr_data}),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level)
  );

  assign wr_valid = ~fifo_empty;
  assign rd_done  = rd_done_q;
  assign rd_addr  = rd_addr_q;
  assign overflow = overflow_q;

endmodule
